// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the quadrature encoder front end.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable.
package encoder_pkg;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    typedef struct packed {
        logic inc;
        logic dec;
        logic illegal;
    } step_t;

    // State is {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic step_t decode_step(input logic [1:0] mode,
                                          input logic [1:0] prev_ab,
                                          input logic [1:0] cur_ab);
        step_t s;
        logic  fwd;
        s   = '0;
        fwd = (prev_ab == 2'b00 && cur_ab == 2'b10) ||
              (prev_ab == 2'b10 && cur_ab == 2'b11) ||
              (prev_ab == 2'b11 && cur_ab == 2'b01) ||
              (prev_ab == 2'b01 && cur_ab == 2'b00);
        if (prev_ab != cur_ab) begin
            if ((prev_ab ^ cur_ab) == 2'b11) begin
                s.illegal = 1'b1;
            end else begin
                case (mode)
                    MODE_X1: begin
                        s.inc = (prev_ab == 2'b00) && (cur_ab == 2'b10);
                        s.dec = (prev_ab == 2'b10) && (cur_ab == 2'b00);
                    end
                    MODE_X2: begin
                        // Only A edges count; direction from A's new level vs B.
                        if (prev_ab[1] != cur_ab[1]) begin
                            s.inc = cur_ab[1] ^ cur_ab[0];
                            s.dec = ~(cur_ab[1] ^ cur_ab[0]);
                        end
                    end
                    default: begin
                        // x4, and the reserved code behaves the same.
                        s.inc = fwd;
                        s.dec = ~fwd;
                    end
                endcase
            end
        end
        return s;
    endfunction

    // Counts per revolution for the given mode, capped at the position range.
    function automatic logic [31:0] calc_modulus(input logic [10:0] ppr,
                                                 input logic [1:0]  mode,
                                                 input int          pos_w);
        logic [31:0] m;
        logic [31:0] lim;
        case (mode)
            MODE_X1: m = {21'd0, ppr};
            MODE_X2: m = {20'd0, ppr, 1'b0};
            default: m = {19'd0, ppr, 2'b00};
        endcase
        lim = 32'd1 << pos_w;
        return (m > lim) ? lim : m;
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: 2-flop sync, per-input debounce, decode, position/rev counter, sticky error.
// Latency: a stable pad level reaches pos DB_CYCLES+3 clocks after the first edge that samples it.
// Backpressure: none; counts are applied every clock, clear discards a coincident count.
module enc_channel
    import encoder_pkg::*;
#(
    parameter int POS_W     = 12,
    parameter int REV_W     = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic [1:0]       mode,
    input  logic [POS_W:0]   modulus,
    input  logic             clear,
    input  logic             err_clr,
    output logic [POS_W-1:0] pos,
    output logic [REV_W-1:0] rev,
    output logic             dir,
    output logic             err
);

    localparam int                MOD_W    = POS_W + 1;
    localparam int                CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db_ab;
    logic [1:0]       prev_ab;
    logic [CNT_W-1:0] db_cnt [2];
    step_t            step_d;
    step_t            step_q;
    logic [POS_W:0]   mod_m1;
    logic             at_top;
    logic             count_en;

    assign step_d   = decode_step(mode, prev_ab, db_ab);
    assign mod_m1   = modulus - MOD_W'(1);
    assign at_top   = ({1'b0, pos} == mod_m1);
    assign count_en = (modulus != '0) && !clear && (step_q.inc || step_q.dec);

    // Two-flop synchroniser on the asynchronous pads, bit 1 = A.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after it has differed for DB_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_ab     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_ab[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_ab[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register the decoded step so counting runs one stage after the debounced edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab <= '0;
            step_q  <= '0;
        end else begin
            prev_ab <= db_ab;
            step_q  <= step_d;
        end
    end

    // Position/revolution counter with modulus wrap, direction and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= '0;
            rev <= '0;
            dir <= 1'b0;
            err <= 1'b0;
        end else begin
            if (clear) begin
                pos <= '0;
                rev <= '0;
            end else if (count_en) begin
                dir <= step_q.inc;
                if (step_q.inc) begin
                    if (at_top) begin
                        pos <= '0;
                        rev <= rev + REV_W'(1);
                    end else begin
                        pos <= pos + POS_W'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        pos <= mod_m1[POS_W-1:0];
                        rev <= rev - REV_W'(1);
                    end else begin
                        pos <= pos - POS_W'(1);
                    end
                end
            end
            // A new illegal transition wins over a coincident clear.
            if (step_q.illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_array.sv
// N-channel quadrature front end with shared ppr/mode and a coherent snapshot register.
// Latency: pos follows pads by DB_CYCLES+3 clocks; snapshot strobes the cycle after snap_req.
// Backpressure: none; every snap_req is served, back-to-back requests give back-to-back strobes.
module quad_encoder_array
    import encoder_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int POS_W     = 12,
    parameter int REV_W     = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [1:0]            mode,
    input  logic [10:0]           ppr,
    input  logic [N_CH-1:0]       err_clr,
    input  logic                  snap_req,
    output logic [N_CH*POS_W-1:0] pos,
    output logic [N_CH*REV_W-1:0] rev,
    output logic [N_CH-1:0]       dir,
    output logic [N_CH-1:0]       err,
    output logic                  snap_valid,
    output logic [N_CH*POS_W-1:0] snap_pos,
    output logic [N_CH*REV_W-1:0] snap_rev
);

    localparam int MOD_W = POS_W + 1;

    logic [10:0]      ppr_q;
    logic [1:0]       mode_q;
    logic             cfg_change;
    logic [POS_W:0]   modulus;

    assign cfg_change = (ppr != ppr_q) || (mode != mode_q);
    assign modulus    = MOD_W'(calc_modulus(ppr, mode, POS_W));

    // Registered copy of the configuration used to detect ppr/mode changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ppr_q  <= '0;
            mode_q <= '0;
        end else begin
            ppr_q  <= ppr;
            mode_q <= mode;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            enc_channel #(
                .POS_W     (POS_W),
                .REV_W     (REV_W),
                .DB_CYCLES (DB_CYCLES)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .a       (a[g]),
                .b       (b[g]),
                .mode    (mode),
                .modulus (modulus),
                .clear   (cfg_change),
                .err_clr (err_clr[g]),
                .pos     (pos[g*POS_W +: POS_W]),
                .rev     (rev[g*REV_W +: REV_W]),
                .dir     (dir[g]),
                .err     (err[g])
            );
        end
    endgenerate

    // Snapshot captures the pre-update counter values of all channels at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_valid <= 1'b0;
            snap_pos   <= '0;
            snap_rev   <= '0;
        end else begin
            snap_valid <= snap_req;
            if (snap_req) begin
                snap_pos <= pos;
                snap_rev <= rev;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array with hand-computed expectations.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: not applicable.
module tb_quad_encoder_array;

    localparam int N_CH      = 2;
    localparam int POS_W     = 12;
    localparam int REV_W     = 8;
    localparam int DB_CYCLES = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       a;
    logic [N_CH-1:0]       b;
    logic [1:0]            mode;
    logic [10:0]           ppr;
    logic [N_CH-1:0]       err_clr;
    logic                  snap_req;
    logic [N_CH*POS_W-1:0] pos;
    logic [N_CH*REV_W-1:0] rev;
    logic [N_CH-1:0]       dir;
    logic [N_CH-1:0]       err;
    logic                  snap_valid;
    logic [N_CH*POS_W-1:0] snap_pos;
    logic [N_CH*REV_W-1:0] snap_rev;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         idx [N_CH];
    logic [1:0] seq [4];
    logic       seen;

    quad_encoder_array #(
        .N_CH      (N_CH),
        .POS_W     (POS_W),
        .REV_W     (REV_W),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .mode       (mode),
        .ppr        (ppr),
        .err_clr    (err_clr),
        .snap_req   (snap_req),
        .pos        (pos),
        .rev        (rev),
        .dir        (dir),
        .err        (err),
        .snap_valid (snap_valid),
        .snap_pos   (snap_pos),
        .snap_rev   (snap_rev)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pos_of(input int c);
        return 32'(pos[c*POS_W +: POS_W]);
    endfunction

    function automatic logic [31:0] rev_of(input int c);
        return 32'(rev[c*REV_W +: REV_W]);
    endfunction

    task automatic drive_pins();
        for (int c = 0; c < N_CH; c++) begin
            a[c] = seq[idx[c]][1];
            b[c] = seq[idx[c]][0];
        end
    endtask

    task automatic step(input logic [N_CH-1:0] mask, input bit fwd, input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < N_CH; c++)
                if (mask[c]) idx[c] = fwd ? (idx[c] + 1) % 4 : (idx[c] + 3) % 4;
            drive_pins();
            repeat (hold) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        for (int c = 0; c < N_CH; c++) idx[c] = 0;
        drive_pins();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        for (int c = 0; c < N_CH; c++) idx[c] = 0;
        reset = 1'b1; a = '0; b = '0; err_clr = '0; snap_req = 1'b0;
        mode = 2'b10; ppr = 11'd64;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pos",   32'(pos), 32'd0);
        chk("rst_rev",   32'(rev), 32'd0);
        chk("rst_dir",   32'(dir), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_sv",    32'(snap_valid), 32'd0);
        chk("rst_spos",  32'(snap_pos), 32'd0);
        chk("rst_srev",  32'(snap_rev), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // x4 latency: first count lands 7 clocks after the sampling edge
        idx[0] = 1;
        drive_pins();
        repeat (7) @(negedge clk);
        chk("lat_before", pos_of(0), 32'd0);
        @(negedge clk);
        chk("lat_at", pos_of(0), 32'd1);
        step(2'b01, 1'b1, 39, 8);
        chk("x4_10cyc_pos", pos_of(0), 32'd40);
        chk("x4_10cyc_rev", rev_of(0), 32'd0);
        chk("x4_10cyc_dir", 32'(dir[0]), 32'd1);

        // x4 wrap through a full revolution, then back
        do_reset();
        step(2'b01, 1'b1, 260, 8);
        chk("x4_260_pos", pos_of(0), 32'd4);
        chk("x4_260_rev", rev_of(0), 32'd1);
        step(2'b01, 1'b0, 10, 8);
        chk("x4_rev10_pos", pos_of(0), 32'd250);
        chk("x4_rev10_rev", rev_of(0), 32'd0);
        chk("x4_rev10_dir", 32'(dir[0]), 32'd0);

        // x1 and x2 decoding
        do_reset();
        mode = 2'b00;
        repeat (2) @(negedge clk);
        step(2'b01, 1'b1, 20, 8);
        chk("x1_pos", pos_of(0), 32'd5);
        mode = 2'b01;
        repeat (2) @(negedge clk);
        chk("mode_clr_pos", pos_of(0), 32'd0);
        step(2'b01, 1'b1, 20, 8);
        chk("x2_pos", pos_of(0), 32'd10);
        mode = 2'b00;
        repeat (2) @(negedge clk);
        step(2'b01, 1'b0, 4, 8);
        chk("x1_under_pos", pos_of(0), 32'd63);
        chk("x1_under_rev", rev_of(0), 32'hFF);
        chk("x1_under_dir", 32'(dir[0]), 32'd0);

        // Glitch one clock shorter than the debounce window
        mode = 2'b10;
        repeat (2) @(negedge clk);
        seen = 1'b0;
        a[0] = 1'b1;
        repeat (DB_CYCLES - 1) @(negedge clk);
        a[0] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (pos_of(0) != 32'd0) seen = 1'b1;
        end
        chk("glitch", 32'(seen), 32'd0);

        // Illegal transition and sticky error
        idx[1] = 2;
        drive_pins();
        repeat (10) @(negedge clk);
        chk("ill_err1", 32'(err[1]), 32'd1);
        chk("ill_pos1", pos_of(1), 32'd0);
        chk("ill_err0", 32'(err[0]), 32'd0);
        idx[1] = 0;
        drive_pins();
        repeat (7) @(negedge clk);
        err_clr[1] = 1'b1;
        @(negedge clk);
        err_clr[1] = 1'b0;
        chk("clr_vs_ill", 32'(err[1]), 32'd1);
        repeat (2) @(negedge clk);
        err_clr[1] = 1'b1;
        @(negedge clk);
        err_clr[1] = 1'b0;
        chk("clr_alone", 32'(err[1]), 32'd0);

        // Saturated modulus at ppr=1024, then config change clears counters
        do_reset();
        ppr = 11'd1024;
        idx[1] = 2;
        drive_pins();
        repeat (2) @(negedge clk);
        step(2'b01, 1'b1, 4095, 6);
        repeat (4) @(negedge clk);
        chk("sat_top_pos", pos_of(0), 32'd4095);
        chk("sat_top_rev", rev_of(0), 32'd0);
        step(2'b01, 1'b1, 1, 8);
        chk("sat_wrap_pos", pos_of(0), 32'd0);
        chk("sat_wrap_rev", rev_of(0), 32'd1);
        step(2'b01, 1'b1, 1, 8);
        chk("sat_next_pos", pos_of(0), 32'd1);
        ppr = 11'd512;
        @(negedge clk);
        chk("ppr_clr_pos", 32'(pos), 32'd0);
        chk("ppr_clr_rev", 32'(rev), 32'd0);
        chk("ppr_keep_err", 32'(err[1]), 32'd1);

        // Snapshot coincident with counts on both channels
        step(2'b01, 1'b1, 3, 8);
        step(2'b10, 1'b1, 2, 8);
        chk("pre_snap_pos", 32'(pos), 32'h002003);
        for (int c = 0; c < N_CH; c++) idx[c] = (idx[c] + 1) % 4;
        drive_pins();
        repeat (7) @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        chk("snap_v1",   32'(snap_valid), 32'd1);
        chk("snap_pre",  32'(snap_pos), 32'h002003);
        chk("live_post", 32'(pos), 32'h003004);
        @(negedge clk);
        chk("snap_v2",   32'(snap_valid), 32'd1);
        chk("snap_b2b",  32'(snap_pos), 32'h003004);
        snap_req = 1'b0;
        @(negedge clk);
        chk("snap_v0",   32'(snap_valid), 32'd0);
        chk("snap_hold", 32'(snap_pos), 32'h003004);
        chk("snap_rev",  32'(snap_rev), 32'd0);

        // Reset mid-stream overrides a pending count and snapshot request
        idx[0] = (idx[0] + 1) % 4;
        drive_pins();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        snap_req = 1'b1;
        @(negedge clk);
        chk("mid_rst_pos",  32'(pos), 32'd0);
        chk("mid_rst_rev",  32'(rev), 32'd0);
        chk("mid_rst_dir",  32'(dir), 32'd0);
        chk("mid_rst_err",  32'(err), 32'd0);
        chk("mid_rst_sv",   32'(snap_valid), 32'd0);
        chk("mid_rst_spos", 32'(snap_pos), 32'd0);
        reset = 1'b0;
        snap_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
